ahb_banked_sram: RTL and testbench

- AHB-lite subordinate with zero wait states, fronting N_BANKS word-interleaved synchronous SRAM banks. Each bank is one sram_wrapper instance.
- Generalises the single-bank SRAM adapter. A buffered write retires to its own bank while a read proceeds in parallel on another bank.
- The write buffer holds data only when a read hits the same bank. A write-to-read forwarding path gives byte-accurate merging.
- Sits on the system AHB-lite fabric as main RAM. Idle banks keep chip-select deasserted to save power.

---
 rtl/ahb_banked_sram.sv | 195 +++++++++++++++++++
 tb/tb_ahb_banked_sram.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_banked_sram.sv
// ahb_banked_sram: zero-wait-state AHB-lite RAM over N_BANKS word-interleaved SRAMs.
// A buffered write retires to its bank while a read proceeds on another bank.
//
// Ports (sram_wrapper): VDD/VSS supplies, clk, chicken_cen_force,
//   cs_n/we_n active-low strobes, be byte enables, addr row, wdata, rdata.
// Ports (ahb_banked_sram): clk, rst (async, active-high), VDD/VSS,
//   chicken_cen_force, ahbls_* AHB-lite subordinate signals.

module sram_wrapper #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 512
) (
  inout  wire                       VDD,
  inout  wire                       VSS,
  input  logic                      clk,
  input  logic                      chicken_cen_force,
  input  logic                      cs_n,
  input  logic                      we_n,
  input  logic [W_DATA/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [W_DATA-1:0]         wdata,
  output logic [W_DATA-1:0]         rdata
);
  logic [W_DATA-1:0] mem [DEPTH];
  logic en;
  logic unused;

  assign unused = VDD ^ VSS;
  assign en = !cs_n || chicken_cen_force;

  always_ff @(posedge clk) begin
    if (en && !we_n) begin
      for (int b = 0; b < W_DATA / 8; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (en && we_n) rdata <= mem[addr];
  end
endmodule

module ahb_banked_sram #(
  parameter int W_DATA  = 32,
  parameter int W_ADDR  = 32,
  parameter int DEPTH   = 2048,
  parameter int N_BANKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               VDD,
  inout  wire               VSS,
  input  logic              chicken_cen_force,
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata
);
  localparam int N_BYTES    = W_DATA / 8;
  localparam int W_BYTEADDR = $clog2(N_BYTES);
  localparam int W_BANK     = $clog2(N_BANKS);
  localparam int W_ROW      = $clog2(DEPTH / N_BANKS);
  localparam int W_BA_I     = W_BYTEADDR > 0 ? W_BYTEADDR : 1;
  localparam int W_BK_I     = W_BANK > 0 ? W_BANK : 1;

  logic [W_BK_I-1:0]  bank_a;
  logic [W_ROW-1:0]   row_a;
  logic [W_BA_I-1:0]  align_a;
  logic               rd_a;
  logic               wr_a;

  logic               wr_pend;
  logic               wbuf_vld;
  logic [W_BK_I-1:0]  pend_bank;
  logic [W_ROW-1:0]   pend_row;
  logic [W_BA_I-1:0]  pend_align;
  logic [2:0]         pend_size;
  logic [W_DATA-1:0]  wbuf_data;

  logic [W_BK_I-1:0]  dp_bank;
  logic [W_ROW-1:0]   dp_row;

  logic [N_BYTES-1:0] mask;
  logic               conflict;
  logic               retire;
  logic               capture;
  logic               fwd;
  logic [W_DATA-1:0]  wdata;

  logic [N_BANKS-1:0] bank_cs_n;
  logic [N_BANKS-1:0] bank_we_n;
  logic [W_DATA-1:0]  bank_rdata [N_BANKS];
  logic               unused;

  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;
  assign unused = ^{ahbls_htrans[0], ahbls_hburst, ahbls_hprot,
                    ahbls_hmastlock, ahbls_haddr};

  // Masking with (count-1) collapses cleanly to zero for 1-bank/8-bit builds.
  assign align_a = W_BA_I'(ahbls_haddr) & W_BA_I'(N_BYTES - 1);
  assign bank_a  = W_BK_I'(ahbls_haddr >> W_BYTEADDR) & W_BK_I'(N_BANKS - 1);
  assign row_a   = W_ROW'(ahbls_haddr >> (W_BYTEADDR + W_BANK));

  assign rd_a = ahbls_htrans[1] && ahbls_hready && !ahbls_hwrite;
  assign wr_a = ahbls_htrans[1] && ahbls_hready && ahbls_hwrite;

  assign conflict = rd_a && (bank_a == pend_bank);
  assign retire   = wr_pend && !conflict;
  assign capture  = wr_pend && !wbuf_vld && conflict;
  assign wdata    = wbuf_vld ? wbuf_data : ahbls_hwdata;

  always_comb begin
    mask = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      mask[b] = (b >= int'(pend_align)) &&
                (b < int'(pend_align) + (1 << pend_size));
    end
  end

  for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
    logic             rd_k;
    logic             wr_k;
    logic [W_ROW-1:0] addr_k;

    assign rd_k = rd_a && (bank_a == W_BK_I'(k));
    assign wr_k = retire && (pend_bank == W_BK_I'(k));
    assign bank_cs_n[k] = !(rd_k || wr_k);
    assign bank_we_n[k] = !wr_k;
    assign addr_k = wr_k ? pend_row : row_a;

    sram_wrapper #(
      .W_DATA (W_DATA),
      .DEPTH  (DEPTH / N_BANKS)
    ) u_sram (
      .VDD               (VDD),
      .VSS               (VSS),
      .clk               (clk),
      .chicken_cen_force (chicken_cen_force),
      .cs_n              (bank_cs_n[k]),
      .we_n              (bank_we_n[k]),
      .be                (mask),
      .addr              (addr_k),
      .wdata             (wdata),
      .rdata             (bank_rdata[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend    <= 1'b0;
      wbuf_vld   <= 1'b0;
      pend_align <= '0;
      pend_size  <= '0;
    end else if (wr_a) begin
      // A write address phase never conflicts, so any older write retires now.
      wr_pend    <= 1'b1;
      wbuf_vld   <= 1'b0;
      pend_align <= align_a;
      pend_size  <= ahbls_hsize;
    end else if (retire) begin
      wr_pend  <= 1'b0;
      wbuf_vld <= 1'b0;
    end else if (capture) begin
      wbuf_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a) begin
      pend_bank <= bank_a;
      pend_row  <= row_a;
    end
    if (capture) wbuf_data <= ahbls_hwdata;
    if (ahbls_hready) begin
      dp_bank <= bank_a;
      dp_row  <= row_a;
    end
  end

  // SRAM still holds old bytes for a buffered write; overlay them on reads.
  always_comb begin
    ahbls_hrdata = bank_rdata[dp_bank];
    fwd = wbuf_vld && (dp_bank == pend_bank) && (dp_row == pend_row);
    for (int b = 0; b < N_BYTES; b++) begin
      if (fwd && mask[b]) ahbls_hrdata[8*b +: 8] = wbuf_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_ahb_banked_sram.sv
// tb_ahb_banked_sram: directed plus randomized checks of ahb_banked_sram
// against a word-array memory model with AHB pipelined write-data timing.

module tb_ahb_banked_sram;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  wire         vdd;
  wire         vss;
  logic        hready_resp;
  logic        hresp;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  ahb_banked_sram dut (
    .clk               (clk),
    .rst               (rst),
    .VDD               (vdd),
    .VSS               (vss),
    .chicken_cen_force (1'b0),
    .ahbls_hready_resp (hready_resp),
    .ahbls_hready      (1'b1),
    .ahbls_hresp       (hresp),
    .ahbls_haddr       (haddr),
    .ahbls_hwrite      (hwrite),
    .ahbls_htrans      (htrans),
    .ahbls_hsize       (hsize),
    .ahbls_hburst      (3'b000),
    .ahbls_hprot       (4'b0011),
    .ahbls_hmastlock   (1'b0),
    .ahbls_hwdata      (hwdata),
    .ahbls_hrdata      (hrdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [DEPTH];

  bit          p_rd = 0;
  logic [31:0] p_exp = '0;
  bit          p_lc = 0;
  logic [31:0] p_le = '0;
  logic [31:0] p_wd = '0;
  bit          dp_chk = 0;
  logic [31:0] dp_exp = '0;
  bit          dp_lc = 0;
  logic [31:0] dp_le = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One address phase; hwdata carries the previous write's data.
  task automatic drive(input bit v, input bit w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] d,
                       input bit lc, input logic [31:0] le);
    int wi;
    int al;
    dp_chk = p_rd;
    dp_exp = p_exp;
    dp_lc  = p_lc;
    dp_le  = p_le;
    hwdata = p_wd;
    htrans = v ? 2'b10 : 2'b00;
    hwrite = w;
    haddr  = a;
    hsize  = sz;
    p_rd = v && !w;
    p_lc = lc && v && !w;
    p_le = le;
    wi = int'((a >> 2) & (DEPTH - 1));
    al = int'(a[1:0]);
    if (v && w) begin
      for (int b = 0; b < 4; b++)
        if (b >= al && b < al + (1 << sz)) mem_m[wi][8*b +: 8] = d[8*b +: 8];
      p_wd = d;
    end else begin
      p_wd = $urandom;
    end
    if (p_rd) p_exp = mem_m[wi];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] sz);
    drive(1, 1, a, sz, d, 0, 0);
    step();
  endtask

  task automatic rdl(input logic [31:0] a, input logic [31:0] le);
    drive(1, 0, a, 3'd2, 0, 1, le);
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 0, 0, 0);
    step();
  endtask

  always @(negedge clk) begin
    chk("hready_resp", {31'b0, hready_resp}, 32'd1);
    chk("hresp", {31'b0, hresp}, 32'd0);
    if (!rst && dp_chk) chk("hrdata_model", hrdata, dp_exp);
    if (!rst && dp_lc) chk("hrdata_literal", hrdata, dp_le);
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int sz;
    logic [31:0] a;
    rst = 1'b1;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr = '0;
    hsize = 3'd0;
    hwdata = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_pend", {31'b0, dut.wr_pend}, 0);
    chk("reset_wbuf_vld", {31'b0, dut.wbuf_vld}, 0);
    chk("reset_cs_n", {28'b0, dut.bank_cs_n}, 32'hF);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) wr(i * 4, 0, 3'd2);
    idle();

    wr(32'h10, 32'hDEADBEEF, 3'd2);
    idle();
    rdl(32'h10, 32'hDEADBEEF);
    idle();

    wr(32'h20, 32'hCAFEF00D, 3'd2);
    drive(1, 0, 32'h20, 3'd2, 0, 1, 32'hCAFEF00D);
    @(negedge clk);
    chk("t2_no_we0", {31'b0, dut.bank_we_n[0]}, 1);
    step();
    chk("t2_wbuf_vld", {31'b0, dut.wbuf_vld}, 1);
    drive(0, 0, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    chk("t2_retire_we0", {31'b0, dut.bank_we_n[0]}, 0);
    step();
    idle();
    rdl(32'h20, 32'hCAFEF00D);
    idle();

    wr(32'h20, 32'h12345678, 3'd2);
    drive(1, 0, 32'h24, 3'd2, 0, 1, 32'h0);
    @(negedge clk);
    chk("t3_we0", {31'b0, dut.bank_we_n[0]}, 0);
    chk("t3_cs1", {31'b0, dut.bank_cs_n[1]}, 0);
    chk("t3_we1", {31'b0, dut.bank_we_n[1]}, 1);
    step();
    chk("t3_wbuf_vld", {31'b0, dut.wbuf_vld}, 0);
    idle();

    wr(32'h20, 32'h11223344, 3'd2);
    idle();
    wr(32'h23, 32'hAB000000, 3'd0);
    rdl(32'h20, 32'hAB223344);
    idle();

    wr(32'h30, 32'h5A5A5A5A, 3'd2);
    rdl(32'h30, 32'h5A5A5A5A);
    rdl(32'h40, 32'h0);
    rdl(32'h30, 32'h5A5A5A5A);
    drive(1, 1, 32'h50, 3'd2, 32'h1, 0, 0);
    @(negedge clk);
    chk("t5_retire_we0", {31'b0, dut.bank_we_n[0]}, 0);
    step();
    idle();
    rdl(32'h30, 32'h5A5A5A5A);
    rdl(32'h50, 32'h1);
    idle();

    wr(32'h60, 32'h77777777, 3'd2);
    drive(1, 0, 32'h60, 3'd2, 0, 0, 0);
    step();
    chk("t6_wbuf_vld_pre", {31'b0, dut.wbuf_vld}, 1);
    rst = 1'b1;
    drive(0, 0, 0, 3'd0, 0, 0, 0);
    mem_m[32'h60 >> 2] = 32'h0;
    p_rd = 0;
    p_lc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_wbuf_vld", {31'b0, dut.wbuf_vld}, 0);
    chk("t6_wr_pend", {31'b0, dut.wr_pend}, 0);
    rst = 1'b0;
    drive(0, 0, 0, 3'd0, 0, 0, 0);
    step();
    rdl(32'h60, 32'h0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      sz = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 15)) << 2;
      else a = 32'($urandom_range(0, 63)) << 2;
      a = a | (32'($urandom_range(0, 7)) << 13);
      a = a | (32'($urandom_range(0, 3)) & ~32'((1 << sz) - 1));
      if (r < 4) drive(1, 1, a, 3'(sz), $urandom, 0, 0);
      else if (r < 8) drive(1, 0, a, 3'd2, 0, 0, 0);
      else drive(0, 0, 0, 3'd0, 0, 0, 0);
      step();
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
